// File: rtl/issue_pkg.sv
// Shared types and sizing for the issue stage in front of the polynomial datapath.
package issue_pkg;

  localparam int X_W         = 8;
  localparam int N_W         = 3;
  localparam int OUT_W       = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_MAX_OUT = 8;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [N_W-1:0] n;
  } req_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Upstream request handshake and datapath-facing bundle of the issue stage.
interface issue_req_if;
  import issue_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] in_x;
  logic [N_W-1:0] in_n;

  modport master (output in_valid, in_x, in_n, input in_ready);
  modport slave  (input in_valid, in_x, in_n, output in_ready);
endinterface

interface issue_dp_if;
  import issue_pkg::*;

  logic           dp_ready;
  logic           dp_valid;
  logic           load;
  logic [X_W-1:0] x;
  logic [N_W-1:0] n;
  logic           controller_inuse;
  logic           flush;

  modport master (output load, x, n, controller_inuse, flush, input dp_ready, dp_valid);
  modport slave  (input load, x, n, controller_inuse, flush, output dp_ready, dp_valid);
endinterface

// File: rtl/issue_ctrl_req_fifo.sv
// Request FIFO: power-of-two depth, pointers carry an extra wrap bit to tell full from empty.
module req_fifo
  import issue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  req_t                     i_data,
  output req_t                     o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  req_t        r_mem [DEPTH];

  // NOTE: the storage array has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: buffers requests, issues one per cycle into the datapath input register,
// and tracks in-flight work against datapath completions.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic             clk,
  input  logic             rst,
  issue_req_if.slave       req,
  issue_dp_if.master       dp,
  input  logic             sw_flush,
  output logic [OUT_W-1:0] outstanding,
  output logic             busy,
  output logic             err
);

  logic                   w_push;
  logic                   w_issue;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  req_t                   w_in_req;
  req_t                   w_head;

  logic                   r_load;
  logic [X_W-1:0]         r_x;
  logic [N_W-1:0]         r_n;
  logic                   r_inuse;
  logic                   r_flush;
  logic [OUT_W-1:0]       r_outstanding;
  logic                   r_err;

  assign w_in_req.x = req.in_x;
  assign w_in_req.n = req.in_n;
  assign w_empty    = (w_count == '0);

  // Gating with rst keeps the upstream stalled for the whole reset window.
  assign req.in_ready = rst && !w_full && !sw_flush;
  assign w_push       = req.in_valid && req.in_ready;

  // The counter already includes last cycle's issue, so no separate pending term is needed.
  assign w_issue = !w_empty && dp.dp_ready && (r_outstanding < OUT_W'(MAX_OUT)) && !sw_flush;

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_clear (sw_flush),
    .i_data  (w_in_req),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Output register: a non-issue cycle always loads a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load  <= 1'b0;
      r_x     <= '0;
      r_n     <= '0;
      r_inuse <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_load  <= 1'b1;
      r_flush <= sw_flush;
      if (w_issue) begin
        r_x     <= w_head.x;
        r_n     <= w_head.n;
        r_inuse <= 1'b1;
      end else begin
        r_x     <= '0;
        r_n     <= '0;
        r_inuse <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else if (sw_flush) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, dp.dp_valid})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // A completion with nothing in flight is a protocol error; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (dp.dp_valid && (r_outstanding == '0)) begin
      r_err <= 1'b1;
    end
  end

  assign dp.load             = r_load;
  assign dp.x                = r_x;
  assign dp.n                = r_n;
  assign dp.controller_inuse = r_inuse;
  assign dp.flush            = r_flush;
  assign outstanding         = r_outstanding;
  assign busy                = !w_empty || (r_outstanding != '0);
  assign err                 = r_err;

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Front-end issue stage that sits directly upstream of the polynomial-evaluation datapath. It accepts (x, n) requests over a valid/ready handshake and buffers them in a small FIFO. It presents one request per cycle to the datapath input register, but only while the datapath reports `ready`. It also tracks in-flight requests against the datapath's `valid` pulses and drives the datapath `flush`.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- MAX_OUT, 8, maximum in-flight requests (issued, not yet completed)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  upstream request valid
- in_ready  out  1  FIFO can accept (not full and no flush this cycle)
- in_x  in  8  signed Q-format operand
- in_n  in  3  requested term count
- sw_flush  in  1  abort request: clear everything, pulse datapath flush
- dp_ready  in  1  datapath `ready` (low while a loop-back occupies stage 1)
- dp_valid  in  1  datapath `valid` (one completion per high cycle)
- load  out  1  datapath input-register load enable
- x  out  8  operand to datapath
- n  out  3  term count to datapath
- controller_inuse  out  1  marks the loaded slot as a real request
- flush  out  1  datapath pipeline flush
- outstanding  out  4  in-flight count
- busy  out  1  FIFO non-empty or outstanding≠0
- err  out  1  sticky: dp_valid seen with outstanding==0

## Operation
- Accept: when in_valid & in_ready, push {in_x, in_n} at the tail.
- Issue condition, evaluated each cycle: `issue = FIFO non-empty & dp_ready & outstanding+pending_issue < MAX_OUT & ~sw_flush`.
- `load` is 1 on every cycle after reset release.
  - It feeds a bubble whenever not issuing, so the datapath input register never re-injects a stale inuse slot.
- On issue, the registered outputs take {x, n} from the head and controller_inuse=1, and the FIFO pops.
- On a non-issue cycle the outputs are x=0, n=0, controller_inuse=0.
- Outstanding counter:
  - +1 on each issue cycle, −1 on each dp_valid.
  - Both together leave it unchanged.
  - A decrement at 0 holds 0 and sets `err`.
- sw_flush, on the cycle it is high:
  - Empties the FIFO and zeroes outstanding.
  - Blocks accept (in_ready=0) and blocks issue.
  - Registers flush=1 for exactly the next cycle, with a bubble on x/n/inuse in that cycle.
- err clears only on reset.
- A simultaneous push and pop on a full FIFO is not possible, because in_ready is 0 when full. A push and pop together at any other occupancy leaves the count unchanged.

## Timing
- Reset values (asynchronous, rst low):
  - load=0, x=0, n=0, controller_inuse=0, flush=0
  - outstanding=0, busy=0, err=0
  - FIFO empty, in_ready=0 while rst low
- First cycle after release: load=1, in_ready=1.
- Latency: a request accepted at edge k with an empty FIFO and dp_ready=1 appears on x/n with controller_inuse=1 after edge k+1, i.e. 2 cycles accept-to-present. No bypass path.
- Throughput: 1 request per cycle while dp_ready=1 and under MAX_OUT.
- dp_ready is sampled in the same cycle as the issue decision.
  - If dp_ready drops, no issue occurs that cycle.
  - The head is held and controller_inuse=0 is presented.
- sw_flush at edge k: flush is high for cycle k+1 only. Requests arriving with in_valid at k are dropped (not accepted).
- Reset mid-operation: all state is discarded immediately and no flush pulse is generated.

## Structure
- Shared package `issue_pkg`:
  - request struct {x[7:0], n[2:0]}
  - X_W=8, N_W=3
  - default DEPTH and MAX_OUT
- One sub-module, `req_fifo`: synchronous FIFO with count, async active-low reset, parameter DEPTH, ptr wrap via extra MSB.
- Issue logic, outstanding counter, and output registers live in `issue_ctrl`.

## Test plan
- Reset then single request: x=0x20, n=3 accepted at cycle 5 → cycle 7 shows load=1, x=0x20, n=3, inuse=1, and outstanding=1 after it. dp_valid pulse → outstanding=0, busy=0.
- Fill the FIFO with dp_ready=0: push 4 requests → in_ready=0 after the 4th and a 5th in_valid is held. Raise dp_ready → 4 consecutive issue cycles in FIFO order, then inuse=0.
- Backpressure: dp_ready toggles 1,0,1,0 with 3 queued → inuse pattern 1,0,1,0,1, and the head holds its value across stalls.
- MAX_OUT=8, never assert dp_valid: push 10 → exactly 8 issued, outstanding=8, 2 remain queued. One dp_valid → the 9th issues next cycle.
- sw_flush with 3 queued and outstanding=5 → next cycle flush=1, inuse=0, outstanding=0, FIFO empty. A concurrent in_valid is not accepted.
- dp_valid with outstanding=0 → err=1 and stays 1 until rst low. Async rst mid-stream clears all outputs without waiting for a clk edge.
